mcu_lsu: RTL and testbench

Load/store unit for the control-processor pipeline, sitting directly downstream of the EX-stage ALU. It takes the effective address computed in EX plus store data and rd, and checks alignment and funct3. It then runs a single-outstanding request/response transaction on the MCU data bus. Loads produce a lane-extracted, sign/zero-extended writeback; stores produce a completion. Faults are reported as precise exceptions to the trap logic.

---
 rtl/mcu_isa_pkg.sv | 22 ++
 rtl/mcu_lsu_align.sv | 72 +++++++
 rtl/mcu_lsu.sv | 182 ++++++++++++++++++
 tb/tb_mcu_lsu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mcu_isa_pkg.sv
// rtl/mcu_isa_pkg.sv - shared ISA constants and LSU state type
package mcu_isa_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mcu_lsu_align.sv
// rtl/mcu_lsu_align.sv - byte-lane enables, store replication, op legality and load extraction
module mcu_lsu_align
  import mcu_isa_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic        is_store_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        illegal_o,
  output logic        misalign_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sext;

  assign sext = ~funct3_i[2];

  always_comb begin
    ld_byte = rdata_i[7:0];
    case (addr_i)
      2'b01:   ld_byte = rdata_i[15:8];
      2'b10:   ld_byte = rdata_i[23:16];
      2'b11:   ld_byte = rdata_i[31:24];
      default: ld_byte = rdata_i[7:0];
    endcase
    ld_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    illegal_o = 1'b1;
    if (is_store_i) begin
      if (funct3_i == LS_B || funct3_i == LS_H || funct3_i == LS_W) illegal_o = 1'b0;
    end else begin
      if (funct3_i == LS_B || funct3_i == LS_H || funct3_i == LS_W ||
          funct3_i == LS_BU || funct3_i == LS_HU) illegal_o = 1'b0;
    end
  end

  // Width is carried in funct3[1:0]; bit 2 only selects zero-extension.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    ld_data_o  = rdata_i;
    misalign_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o      = 4'b0001 << addr_i;
        wdata_o   = {4{wdata_i[7:0]}};
        ld_data_o = {{24{sext & ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        be_o       = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        ld_data_o  = {{16{sext & ld_half[15]}}, ld_half};
        misalign_o = addr_i[0];
      end
      2'b10: begin
        be_o       = 4'b1111;
        misalign_o = (addr_i != 2'b00);
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mcu_lsu.sv
// rtl/mcu_lsu.sv - single-outstanding load/store unit with precise exceptions
module mcu_lsu
  import mcu_isa_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [3:0]        mem_req_be,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  input  logic              mem_rsp_err,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_tval
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              store_q, store_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              done_q, done_d;
  logic              exc_valid_q, exc_valid_d;
  logic [3:0]        exc_cause_q, exc_cause_d;
  logic [ADDR_W-1:0] exc_tval_q, exc_tval_d;

  logic              idle;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic              al_illegal;
  logic              al_misalign;
  logic [31:0]       al_ld_data;

  assign idle = (state_q == LSU_IDLE);

  // In IDLE the helper checks the incoming op; otherwise it extracts for the held op.
  mcu_lsu_align u_align (
    .funct3_i   (idle ? ex_funct3 : f3_q),
    .addr_i     (idle ? ex_addr[1:0] : addr_q[1:0]),
    .is_store_i (ex_is_store),
    .wdata_i    (ex_wdata),
    .rdata_i    (mem_rsp_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .illegal_o  (al_illegal),
    .misalign_o (al_misalign),
    .ld_data_o  (al_ld_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    store_d     = store_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    done_d      = 1'b0;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_tval_d  = exc_tval_q;
    case (state_q)
      LSU_IDLE: begin
        if (ex_valid) begin
          if (al_illegal) begin
            exc_valid_d = 1'b1;
            exc_cause_d = EXC_ILLEGAL;
            exc_tval_d  = ex_addr;
          end else if (al_misalign) begin
            exc_valid_d = 1'b1;
            exc_cause_d = ex_is_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
            exc_tval_d  = ex_addr;
          end else begin
            state_d = LSU_REQ;
            addr_d  = ex_addr;
            be_d    = al_be;
            wdata_d = al_wdata;
            f3_d    = ex_funct3;
            rd_d    = ex_rd;
            store_d = ex_is_store;
          end
        end
      end
      LSU_REQ: begin
        if (mem_req_ready) state_d = LSU_RSP;
      end
      LSU_RSP: begin
        if (mem_rsp_valid) begin
          state_d = LSU_IDLE;
          if (mem_rsp_err) begin
            exc_valid_d = 1'b1;
            exc_cause_d = store_q ? EXC_ST_FAULT : EXC_LD_FAULT;
            exc_tval_d  = addr_q;
          end else begin
            done_d = 1'b1;
            if (!store_q) begin
              wb_valid_d = 1'b1;
              wb_rd_d    = rd_q;
              wb_data_d  = al_ld_data;
            end
          end
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      store_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      done_q      <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_tval_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      store_q     <= store_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      done_q      <= done_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_tval_q  <= exc_tval_d;
    end
  end

  assign ex_ready      = idle;
  assign mem_req_valid = (state_q == LSU_REQ);
  assign mem_req_we    = mem_req_valid & store_q;
  assign mem_req_addr  = mem_req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_req_be    = mem_req_valid ? be_q : 4'b0000;
  assign mem_req_wdata = mem_req_valid ? wdata_q : '0;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign done          = done_q;
  assign exc_valid     = exc_valid_q;
  assign exc_cause     = exc_cause_q;
  assign exc_tval      = exc_tval_q;

endmodule

// File: tb/tb_mcu_lsu.sv
// tb/tb_mcu_lsu.sv - directed self-checking bench for mcu_lsu
module tb_mcu_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid, done, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_tval;
  logic [3:0]  exc_cause;

  int vectors = 0;
  int miscompares = 0;

  logic        s_rv, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;

  always #5 clk = ~clk;

  mcu_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full op with an immediately-ready bus; returns at the negedge of the pulse cycle.
  task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic [4:0] rd,
                    input logic [31:0] rdata, input logic err);
    ex_valid = 1'b1; ex_is_store = st; ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    @(negedge clk);
    ex_valid = 1'b0;
    s_rv = mem_req_valid; s_we = mem_req_we; s_addr = mem_req_addr;
    s_be = mem_req_be; s_wdata = mem_req_wdata;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata; mem_rsp_err = err;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_is_store = 1'b0; ex_funct3 = '0;
    ex_addr = '0; ex_wdata = '0; ex_rd = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111_2222; mem_rsp_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_pulses", {29'd0, wb_valid, done, exc_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("stale_rsp_idle", {29'd0, wb_valid, done, exc_valid}, 32'd0);
    mem_rsp_valid = 1'b0;

    // LW 0x100
    op(1'b0, 3'b010, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 1'b0);
    chk("lw_req_valid", {31'd0, s_rv}, 32'd1);
    chk("lw_req_we", {31'd0, s_we}, 32'd0);
    chk("lw_req_addr", s_addr, 32'h100);
    chk("lw_be", {28'd0, s_be}, 32'hF);
    chk("lw_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lw_wb_rd", {27'd0, wb_rd}, 32'd7);
    chk("lw_wb_data", wb_data, 32'hDEADBEEF);
    chk("lw_done", {31'd0, done}, 32'd1);
    chk("lw_ex_ready", {31'd0, ex_ready}, 32'd1);

    // LB / LBU / LH extraction
    op(1'b0, 3'b000, 32'h103, 32'h0, 5'd1, 32'h80FF_0000, 1'b0);
    chk("lb_be", {28'd0, s_be}, 32'h8);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    op(1'b0, 3'b100, 32'h103, 32'h0, 5'd2, 32'h80FF_0000, 1'b0);
    chk("lbu_data", wb_data, 32'h00000080);
    op(1'b0, 3'b001, 32'h102, 32'h0, 5'd3, 32'h80FF_0000, 1'b0);
    chk("lh_be", {28'd0, s_be}, 32'hC);
    chk("lh_data", wb_data, 32'hFFFF80FF);
    op(1'b0, 3'b101, 32'h100, 32'h0, 5'd0, 32'h1234_F00D, 1'b0);
    chk("lhu_rd0_wb", {26'd0, wb_valid, wb_rd}, {26'd0, 1'b1, 5'd0});
    chk("lhu_data", wb_data, 32'h0000F00D);

    // SH 0x202
    op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd9, 32'h0, 1'b0);
    chk("sh_req_addr", s_addr, 32'h200);
    chk("sh_be", {28'd0, s_be}, 32'hC);
    chk("sh_wdata", s_wdata, 32'hABCDABCD);
    chk("sh_we", {31'd0, s_we}, 32'd1);
    chk("sh_done_wb", {30'd0, done, wb_valid}, 32'h2);
    chk("sh_wb_data_hold", wb_data, 32'h0000F00D);

    // LW misaligned
    ex_valid = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h101;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("lw_mis_exc", {27'd0, exc_valid, exc_cause}, {27'd0, 1'b1, 4'd4});
    chk("lw_mis_tval", exc_tval, 32'h101);
    chk("lw_mis_noreq", {30'd0, mem_req_valid, done}, 32'd0);
    @(negedge clk);
    chk("lw_mis_after", {29'd0, exc_valid, mem_req_valid, ex_ready}, 32'd1);

    // SH misaligned, then SW with illegal funct3
    ex_valid = 1'b1; ex_is_store = 1'b1; ex_funct3 = 3'b001; ex_addr = 32'h201;
    @(negedge clk);
    chk("sh_mis_exc", {27'd0, exc_valid, exc_cause}, {27'd0, 1'b1, 4'd6});
    ex_funct3 = 3'b011; ex_addr = 32'h300;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("ill_exc", {27'd0, exc_valid, exc_cause}, {27'd0, 1'b1, 4'd2});
    chk("ill_tval", exc_tval, 32'h300);
    chk("ill_noreq", {31'd0, mem_req_valid}, 32'd0);

    // SB stalled in REQ with a stray response
    ex_valid = 1'b1; ex_is_store = 1'b1; ex_funct3 = 3'b000; ex_addr = 32'h301; ex_wdata = 32'hAA55;
    @(negedge clk);
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = (i == 1);
      chk("stall_payload", {mem_req_addr[31:8], mem_req_be, mem_req_valid, ex_ready, done, mem_req_we},
          {24'h000003, 4'b0010, 4'b1001});
      chk("stall_wdata", mem_req_wdata, 32'h55555555);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    chk("stall_no_done", {30'd0, done, wb_valid}, 32'd0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("stall_rsp_state", {30'd0, mem_req_valid, ex_ready}, 32'd0);
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("sb_done", {29'd0, done, wb_valid, exc_valid}, 32'h4);

    // Load bus error
    op(1'b0, 3'b010, 32'h400, 32'h0, 5'd5, 32'hCAFEF00D, 1'b1);
    chk("lerr_exc", {27'd0, exc_valid, exc_cause}, {27'd0, 1'b1, 4'd5});
    chk("lerr_tval", exc_tval, 32'h400);
    chk("lerr_nowb", {30'd0, wb_valid, done}, 32'd0);
    chk("lerr_wb_hold", wb_data, 32'h0000F00D);

    // Reset while in RSP, then a late response
    ex_valid = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h500;
    @(negedge clk);
    ex_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rrsp_ex_ready", {31'd0, ex_ready}, 32'd1);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h12345678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rrsp_no_pulse", {28'd0, wb_valid, done, exc_valid, ex_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
